// File: rtl/frame_reader_pkg.sv
// frame_reader_pkg
// Shared definitions for the frame reader and its output FIFO:
//   - default output-buffer depth
//   - controller state encoding
//   - bit positions of the line/frame tags carried beside each pixel
package frame_reader_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Tag field sits above the pixel data in each FIFO word.
  localparam int TAG_W   = 2;
  localparam int TAG_EOL = 0;
  localparam int TAG_EOF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/frame_reader_fifo.sv
// frame_reader_fifo
// Single-clock FIFO buffering store read data (plus tags) for the pixel port.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wr_data   write strobe and word
//   pop, rd_data    read strobe and head word (rd_data valid while !empty)
//   full, empty     status flags
//   count           number of words held (0..DEPTH)
module frame_reader_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  // The reader's credit accounting must never push into a full buffer.
  always_ff @(posedge clk) begin
    if (!rst && push) assert (!full);
  end

endmodule

// File: rtl/frame_reader.sv
// frame_reader
// Scans one image out of the image store in raster order and streams it
// to the pixel path with a valid/ready handshake.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start, i_img_sel        start pulse (honoured only when idle), image index
//   o_busy, o_done            frame in progress, one-cycle completion pulse
//   o_mem_addr, o_mem_write   store address, write enable (always 0)
//   i_mem_data                store read data, one cycle after the address
//   o_pix_data/valid/ready    pixel stream handshake
//   o_pix_eol, o_pix_eof      last pixel of line / of frame, qualified by valid
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int NUM_IMG    = 4,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int SEL_W     = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [SEL_W-1:0]      i_img_sel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_pix_data,
  output logic                  o_pix_valid,
  input  logic                  i_pix_ready,
  output logic                  o_pix_eol,
  output logic                  o_pix_eof
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = DATA_WIDTH + TAG_W;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] base;
  logic [SEL_W-1:0]      sel_c;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic                  inflight;
  logic [TAG_W-1:0]      tag_q;
  logic [TAG_W-1:0]      issue_tag;
  logic                  last_x;
  logic                  last_y;
  logic                  issue;
  logic                  pop;
  logic                  drain_ok;

  logic [FW-1:0]         fifo_rd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;

  assign sel_c = (32'(i_img_sel) >= 32'(NUM_IMG)) ? SEL_W'(NUM_IMG - 1) : i_img_sel;
  assign base  = ADDR_WIDTH'(sel_c) * ADDR_WIDTH'(IMG_W * IMG_H);

  assign last_x = (x == XW'(IMG_W - 1));
  assign last_y = (y == YW'(IMG_H - 1));

  always_comb begin
    issue_tag          = '0;
    issue_tag[TAG_EOL] = last_x;
    issue_tag[TAG_EOF] = last_x && last_y;
  end

  // Credit: words buffered plus the read in flight must leave room for one more.
  assign issue = (state == ST_FETCH) && !fifo_full &&
                 ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));

  assign pop = o_pix_valid && i_pix_ready;

  // Leave DRAIN on the very edge that hands off the final pixel.
  assign drain_ok = !inflight &&
                    (fifo_empty || ((fifo_count == CW'(1)) && pop));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (i_start) next_state = ST_FETCH;
      ST_FETCH: if (issue && last_x && last_y) next_state = ST_DRAIN;
      ST_DRAIN: if (drain_ok) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != ST_IDLE);
    o_done = (state == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr     <= '0;
      x        <= '0;
      y        <= '0;
      inflight <= 1'b0;
      tag_q    <= '0;
    end else begin
      inflight <= issue;
      if (state == ST_IDLE && i_start) begin
        addr <= base;
        x    <= '0;
        y    <= '0;
      end else if (issue) begin
        addr  <= addr + 1'b1;
        tag_q <= issue_tag;
        if (last_x) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  assign o_mem_addr  = addr;
  assign o_mem_write = 1'b0;

  frame_reader_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (inflight),
    .wr_data ({tag_q, i_mem_data}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign o_pix_valid = !fifo_empty;
  assign o_pix_data  = fifo_rd[DATA_WIDTH-1:0];
  assign o_pix_eol   = fifo_rd[DATA_WIDTH + TAG_EOL];
  assign o_pix_eof   = fifo_rd[DATA_WIDTH + TAG_EOF];

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: store model returns data one cycle after
// the address; every pixel, tag, stall hold, credit limit and done pulse is
// checked against values computed from the image index and pixel position.
module tb_frame_reader;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [1:0] i_img_sel;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_mem_addr;
  logic       o_mem_write;
  logic [7:0] mem_data;
  logic [7:0] o_pix_data;
  logic       o_pix_valid;
  logic       i_pix_ready;
  logic       o_pix_eol;
  logic       o_pix_eof;

  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;
  int writes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[o_mem_addr];

  frame_reader dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_img_sel   (i_img_sel),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_mem_addr  (o_mem_addr),
    .o_mem_write (o_mem_write),
    .i_mem_data  (mem_data),
    .o_pix_data  (o_pix_data),
    .o_pix_valid (o_pix_valid),
    .i_pix_ready (i_pix_ready),
    .o_pix_eol   (o_pix_eol),
    .o_pix_eof   (o_pix_eof)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pattern 0: ready high; 1: ready 1-0-0-1 repeating; 2: ready low for 20 cycles
  task automatic run_frame(input int sel, input int pattern, input bit mid_start,
                           input int abort_at);
    int base, popped, first, last_hs, done_cnt, done_cyc, held_d, held_l, held_f;
    bit rdy, stalled, finished;
    logic [7:0] issued8;
    base = sel * 64; popped = 0; first = -1; last_hs = -100;
    done_cnt = 0; done_cyc = -1; stalled = 0; finished = 0;
    held_d = 0; held_l = 0; held_f = 0;
    i_img_sel = 2'(sel);
    i_start   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", int'(o_busy), 1);
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      case (pattern)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = (cyc >= 20);
      endcase
      i_pix_ready = rdy;
      if (mid_start && cyc == 40) begin
        i_start   = 1'b1;
        i_img_sel = 2'd3;
      end else begin
        i_start = 1'b0;
      end
      if (abort_at >= 0 && popped == abort_at) begin
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("abort_valid", int'(o_pix_valid), 0);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_done", int'(o_done), 0);
        repeat (5) begin
          @(negedge clk);
          chk("abort_no_done", int'(o_done), 0);
          chk("abort_no_valid", int'(o_pix_valid), 0);
        end
        return;
      end
      if (o_mem_write) writes++;
      issued8 = o_mem_addr - 8'(base);
      chk("credit_limit", int'((int'(issued8) - popped) <= 4), 1);
      if (pattern == 2 && (cyc == 10 || cyc == 19)) begin
        chk("stall_reads", int'(issued8), 4);
        chk("stall_head", int'(o_pix_data), base);
        chk("stall_valid", int'(o_pix_valid), 1);
      end
      if (stalled) begin
        chk("hold_valid", int'(o_pix_valid), 1);
        chk("hold_data", int'(o_pix_data), held_d);
        chk("hold_eol", int'(o_pix_eol), held_l);
        chk("hold_eof", int'(o_pix_eof), held_f);
      end
      if (o_pix_valid && first < 0) first = cyc;
      if (o_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          chk("done_timing", cyc - last_hs, 1);
          chk("done_all_pixels", popped, 64);
          chk("busy_in_done", int'(o_busy), 1);
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) chk("idle_after_done", int'(o_busy), 0);
      if (o_pix_valid && rdy) begin
        chk("pix_data", int'(o_pix_data), base + popped);
        chk("pix_eol", int'(o_pix_eol), int'((popped % 8) == 7));
        chk("pix_eof", int'(o_pix_eof), int'(popped == 63));
        popped++;
        last_hs = cyc;
      end
      stalled = o_pix_valid && !rdy;
      held_d  = int'(o_pix_data);
      held_l  = int'(o_pix_eol);
      held_f  = int'(o_pix_eof);
      if (done_cyc >= 0 && cyc == done_cyc + 3) finished = 1'b1;
      @(negedge clk);
    end
    chk("frame_finished", int'(finished), 1);
    chk("abort_point_reached", int'(abort_at < 0), 1);
    chk("done_pulses", done_cnt, 1);
    chk("first_valid_latency", first, 2);
    if (pattern == 0) chk("throughput", last_hs - first, 63);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    i_rst = 1'b1; i_start = 1'b0; i_img_sel = 2'd0; i_pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_valid", int'(o_pix_valid), 0);
    chk("rst_addr", int'(o_mem_addr), 0);
    chk("rst_write", int'(o_mem_write), 0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(o_busy), 0);

    run_frame(0, 0, 1'b0, -1);
    run_frame(2, 0, 1'b0, -1);
    run_frame(1, 1, 1'b0, -1);
    run_frame(3, 2, 1'b0, -1);
    run_frame(1, 0, 1'b1, -1);
    run_frame(2, 0, 1'b0, 30);
    run_frame(3, 0, 1'b0, -1);

    chk("no_writes", writes, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Downstream consumer of the encrypting image store.
- Scans one selected image out of the store in raster order (row-major, x fastest) and presents it as a pixel stream with valid/ready handshake toward the VGA pixel path.
- Owns the store's address and write-enable during display; never writes.
- Buffers read data in a small FIFO so VGA-side back-pressure never loses a read.

Parameters:
ADDR_WIDTH, 8, store address width
DATA_WIDTH, 8, pixel/word width
IMG_W, 8, pixels per line
IMG_H, 8, lines per image
NUM_IMG, 4, images resident in store; NUM_IMG*IMG_W*IMG_H must be <= 2**ADDR_WIDTH
FIFO_DEPTH, 4, output buffer entries (power of two, >= 2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  one-cycle pulse: begin reading a frame; ignored unless IDLE
i_img_sel  in  clog2(NUM_IMG)  image index, sampled on accepted i_start
o_busy  out  1  high from accepted start until done pulse (inclusive)
o_done  out  1  one-cycle pulse after last pixel handshaken
o_mem_addr  out  ADDR_WIDTH  store address
o_mem_write  out  1  tied 0 (read-only master)
i_mem_data  in  DATA_WIDTH  store read data
o_pix_data  out  DATA_WIDTH  pixel value
o_pix_valid  out  1  pixel available
i_pix_ready  in  1  consumer accepts
o_pix_eol  out  1  qualifies o_pix_data as last pixel of a line
o_pix_eof  out  1  qualifies o_pix_data as last pixel of frame

Behaviour:
- Reset (i_rst high at posedge): state IDLE, o_busy=0, o_done=0, o_pix_valid=0, o_mem_addr=0, FIFO emptied, in-flight flag cleared. Reset mid-frame aborts immediately; no done pulse; stale in-flight data discarded.
- Store read timing: address held on o_mem_addr during cycle c is sampled at the closing edge; data is valid on i_mem_data during cycle c+1 and captured into FIFO at the end of c+1. One read in flight at a time per cycle (fully pipelined, one issue per cycle max).
- Base address = i_img_sel*IMG_W*IMG_H, computed at start in ADDR_WIDTH bits; i_img_sel >= NUM_IMG clamps to NUM_IMG-1.
- States:
  - IDLE: i_start -> FETCH; latch base, x=0, y=0.
  - FETCH: issue read when (fifo_count + inflight) < FIFO_DEPTH; each issue advances x, wraps x at IMG_W-1 to 0 and increments y. After issuing pixel (IMG_W-1, IMG_H-1) -> DRAIN.
  - DRAIN: wait until in-flight clear and FIFO empty with last pixel handshaken -> DONE.
  - DONE: o_done=1 for exactly one cycle -> IDLE.
- eol/eof tags are computed at issue and carried through FIFO alongside data (FIFO width DATA_WIDTH+2).
- Output: o_pix_valid = FIFO non-empty; transfer on valid&ready; o_pix_data/eol/eof stable while valid&!ready.
- FIFO simultaneous push and pop when full-accounting allows: count unchanged. Credit rule guarantees no overflow; assertion: push never when full.
- i_start while busy: ignored, no effect on current frame.
- Throughput: with i_pix_ready held high, one pixel per cycle; first o_pix_valid 2 cycles after accepted start.

Decomposition:
- Shared package: FIFO_DEPTH default, state encoding (IDLE, FETCH, DRAIN, DONE), tag bit positions (EOL, EOF).
- One sub-module: frame_reader_fifo (synchronous FIFO, same clock/reset, push/pop/full/empty/count).

Test Plan:
- Reset then start img_sel=0, ready=1, store preloaded addr k = k -> 64 pixels 0..63 on consecutive cycles, eol on 7,15,...,63, eof only on 63, done pulse 1 cycle after 63's handshake.
- start img_sel=2 -> first pixel from address 128, last from 191; o_mem_write never 1.
- Ready toggled 1-0-0-1 repeating -> no pixel dropped or duplicated, data stable while stalled, FIFO count never exceeds 4.
- Ready held 0 for 20 cycles after start -> exactly 4 reads issued then address frozen; releasing ready resumes in order.
- i_start pulsed mid-frame with img_sel=3 -> ignored, frame completes from original image, single done pulse.
- i_rst asserted at pixel 30 -> next cycle o_pix_valid=0, o_busy=0, no done; new start returns pixel 0 of selected image correctly.
